// File: rtl/fire_sched_pkg.sv
// Shared types and constants for the fire-stage scheduler.
package fire_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQUEEZE = 3'd1,
    EXPAND  = 3'd2,
    ACK     = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Interleave slot inside the concatenated output RAM: addr = 2*pix + slot.
  localparam logic SLOT_E1 = 1'b0;
  localparam logic SLOT_E3 = 1'b1;

endpackage

// File: rtl/fire_wr_merge.sv
// Merges expand1/expand3 sample pulses into one RAM write port with a 1-deep
// holding register for expand3 when both layers produce in the same cycle.
module fire_wr_merge
  import fire_sched_pkg::*;
#(
  parameter int AW   = 5,
  parameter int NPIX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active,
  input  logic          clear,
  input  logic          e1_sample,
  input  logic          e3_sample,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] pix_cnt,
  output logic          hold_vld,
  output logic          err_ovf
);

  logic [AW-1:0] cnt_e3, hold_addr, addr1, addr3;
  logic          s1, s3;

  // A saturated counter means the layer has over-produced; such samples are dropped.
  assign s1    = active & e1_sample & (pix_cnt != AW'(NPIX));
  assign s3    = active & e3_sample & (cnt_e3  != AW'(NPIX));
  assign addr1 = {pix_cnt[AW-2:0], SLOT_E1};
  assign addr3 = {cnt_e3[AW-2:0],  SLOT_E3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      cnt_e3    <= '0;
      hold_addr <= '0;
      hold_vld  <= 1'b0;
      err_ovf   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (clear) begin
        pix_cnt <= '0;
        cnt_e3  <= '0;
      end else begin
        if (s1) pix_cnt <= pix_cnt + 1'b1;
        if (s3) cnt_e3  <= cnt_e3 + 1'b1;
      end
      // Priority: fresh expand1, then held expand3, then fresh expand3.
      if (s1) begin
        wr_en   <= 1'b1;
        wr_addr <= addr1;
        if (s3) begin
          if (hold_vld) err_ovf <= 1'b1;
          else begin
            hold_addr <= addr3;
            hold_vld  <= 1'b1;
          end
        end
      end else if (hold_vld) begin
        wr_en   <= 1'b1;
        wr_addr <= hold_addr;
        if (s3) hold_addr <= addr3;
        else    hold_vld  <= 1'b0;
      end else if (s3) begin
        wr_en   <= 1'b1;
        wr_addr <= addr3;
      end
    end
  end

endmodule

// File: rtl/fire_stage_scheduler.sv
// Sequences one fire stage: squeeze, then both expands, then RAM ack and done.
// Optional watchdog enabled by defining FIRE_SCHED_WATCHDOG_EN.
module fire_stage_scheduler
  import fire_sched_pkg::*;
#(
  parameter int WOUT        = 16,
  parameter int AW          = $clog2(WOUT**2) + 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          squeeze_finish,
  input  logic          expand1_finish,
  input  logic          expand3_finish,
  input  logic          expand1_sample,
  input  logic          expand3_sample,
  output logic          squeeze_en,
  output logic          expand1_en,
  output logic          expand3_en,
  output logic          ram_feedback,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          done
`ifdef FIRE_SCHED_WATCHDOG_EN
  ,
  output logic          timeout
`endif
);

  localparam int NPIX = WOUT * WOUT;

  state_t        state, next_state;
  logic          f1, f3, enter_exp, exp_done, wd_hit, hold_vld, err_ovf;
  logic [AW-1:0] pix_cnt;

  assign enter_exp = (state == SQUEEZE) && squeeze_finish;
  // Current-cycle finish levels count too, so the last finish need not be latched first.
  assign exp_done  = (f1 | expand1_finish) && (f3 | expand3_finish) &&
                     (pix_cnt == AW'(NPIX)) && !hold_vld;

`ifdef FIRE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            run;
  assign run    = (state == SQUEEZE) || (state == EXPAND);
  assign wd_hit = run && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt  <= run ? wd_cnt + 1'b1 : '0;
      timeout <= wd_hit;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SQUEEZE;
      SQUEEZE: if (wd_hit) next_state = IDLE;
               else if (squeeze_finish) next_state = EXPAND;
      EXPAND:  if (wd_hit) next_state = IDLE;
               else if (exp_done) next_state = ACK;
      ACK:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    ram_feedback = (state == ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squeeze_en <= 1'b0;
      expand1_en <= 1'b0;
      expand3_en <= 1'b0;
      f1         <= 1'b0;
      f3         <= 1'b0;
    end else begin
      squeeze_en <= (state == SQUEEZE);
      expand1_en <= (state == EXPAND);
      expand3_en <= (state == EXPAND);
      if (enter_exp) begin
        f1 <= 1'b0;
        f3 <= 1'b0;
      end else if (state == EXPAND) begin
        f1 <= f1 | expand1_finish;
        f3 <= f3 | expand3_finish;
      end
    end
  end

  fire_wr_merge #(.AW(AW), .NPIX(NPIX)) u_merge (
    .clk       (clk),
    .rst       (rst),
    .active    (state == EXPAND),
    .clear     (enter_exp),
    .e1_sample (expand1_sample),
    .e3_sample (expand3_sample),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .pix_cnt   (pix_cnt),
    .hold_vld  (hold_vld),
    .err_ovf   (err_ovf)
  );

endmodule

// File: tb/tb_fire_stage_scheduler.sv
// Scoreboard bench for fire_stage_scheduler (WOUT=4): expected write addresses
// are queued when samples are driven and popped as wr_en pulses appear.
module tb_fire_stage_scheduler;
  localparam int WOUT = 4;
  localparam int NPIX = 16;
  localparam int AW   = 5;
  localparam int TO   = 100;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, squeeze_finish = 1'b0;
  logic expand1_finish = 1'b0, expand3_finish = 1'b0;
  logic expand1_sample = 1'b0, expand3_sample = 1'b0;
  logic squeeze_en, expand1_en, expand3_en, ram_feedback, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
`ifdef FIRE_SCHED_WATCHDOG_EN
  logic timeout;
`endif

  int n_cmp = 0, n_err = 0;
  int rf_cnt = 0, done_cnt = 0, to_cnt = 0;
  int m1 = 0, m3 = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fire_stage_scheduler #(.WOUT(WOUT), .AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .squeeze_finish(squeeze_finish),
    .expand1_finish(expand1_finish), .expand3_finish(expand3_finish),
    .expand1_sample(expand1_sample), .expand3_sample(expand3_sample),
    .squeeze_en(squeeze_en), .expand1_en(expand1_en), .expand3_en(expand3_en),
    .ram_feedback(ram_feedback), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done)
`ifdef FIRE_SCHED_WATCHDOG_EN
    , .timeout(timeout)
`endif
  );

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_q.size() == 0) chk("wr_unexp", int'(wr_en), 0);
        else chk("wr_addr", int'(wr_addr), exp_q.pop_front());
      end
      if (ram_feedback) rf_cnt++;
      if (done) done_cnt++;
`ifdef FIRE_SCHED_WATCHDOG_EN
      if (timeout) to_cnt++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_stage();
    rf_cnt = 0; done_cnt = 0; m1 = 0; m3 = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    chk("sq_en", int'(squeeze_en), 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("sq_en_spurious", int'(squeeze_en), 1);
    chk("e1_en_in_sq", int'(expand1_en), 0);
    squeeze_finish = 1'b1; tick(); squeeze_finish = 1'b0;
    tick();
    chk("e1_en", int'(expand1_en), 1);
    chk("e3_en", int'(expand3_en), 1);
    chk("sq_en_off", int'(squeeze_en), 0);
  endtask

  task automatic samples(input bit collide, input int n);
    for (int k = 0; k < n; k++) begin
      if (collide) begin
        expand1_sample = 1'b1; expand3_sample = 1'b1;
        exp_q.push_back(2*m1); exp_q.push_back(2*m3 + 1); m1++; m3++;
        tick();
        expand1_sample = 1'b0; expand3_sample = 1'b0;
        tick();
      end else begin
        expand1_sample = 1'b1; exp_q.push_back(2*m1); m1++;
        tick();
        expand1_sample = 1'b0; expand3_sample = 1'b1; exp_q.push_back(2*m3 + 1); m3++;
        tick();
        expand3_sample = 1'b0;
      end
    end
  endtask

  task automatic finish_stage(input string tag);
    int i;
    expand1_finish = 1'b1; expand3_finish = 1'b1;
    for (i = 0; i < 100 && done_cnt == 0; i++) tick();
    tick();
    expand1_finish = 1'b0; expand3_finish = 1'b0;
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_rf"}, rf_cnt, 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_qleft"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'({squeeze_en, expand1_en, expand3_en}), 0);
    chk("rst_wr", int'({ram_feedback, wr_en, done}), 0);
    chk("rst_addr", int'(wr_addr), 0);
    rst = 1'b0; tick();

    // Samples in IDLE must produce no write and no state change.
    expand1_sample = 1'b1; expand3_sample = 1'b1;
    repeat (3) tick();
    expand1_sample = 1'b0; expand3_sample = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    // Nominal staggered run.
    begin_stage();
    samples(1'b0, NPIX);
    finish_stage("nom");

    // Same-cycle samples for every pixel.
    begin_stage();
    samples(1'b1, NPIX);
    finish_stage("coll");
    chk("err_ovf", int'(dut.u_merge.err_ovf), 0);

    // expand1 finishes 50 cycles before expand3.
    begin_stage();
    expand1_finish = 1'b1;
    samples(1'b0, NPIX);
    repeat (50 - 2*NPIX) tick();
    chk("skew_in_exp", int'(expand1_en), 1);
    chk("skew_no_rf", rf_cnt, 0);
    finish_stage("skew");

    // Reset in the middle of EXPAND, then a clean rerun from address 0.
    begin_stage();
    samples(1'b0, 7);
    tick();
    chk("mid_q", exp_q.size(), 0);
    rst = 1'b1; #1;
    chk("mid_en", int'({squeeze_en, expand1_en, expand3_en}), 0);
    chk("mid_wr", int'(wr_en), 0);
    chk("mid_busy", int'(busy), 0);
    repeat (2) tick();
    rst = 1'b0; tick();
    chk("mid_rf", rf_cnt, 0);
    begin_stage();
    samples(1'b0, NPIX);
    finish_stage("rerun");

`ifdef FIRE_SCHED_WATCHDOG_EN
    begin
      int n;
      to_cnt = 0; done_cnt = 0; rf_cnt = 0; n = 0;
      start = 1'b1; tick(); start = 1'b0;
      while (to_cnt == 0 && n < 3*TO) begin
        tick(); n++;
        if (timeout) break;
      end
      chk("wd_cycles", n, TO);
      tick();
      chk("wd_pulse", to_cnt, 1);
      chk("wd_busy", int'(busy), 0);
      chk("wd_done", done_cnt, 0);
      chk("wd_rf", rf_cnt, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
